// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Scan sequencer that owns the Select bus of an NINPUTS_MUX:1 mux. On start it
// steps Select through the channels. For each channel it waits SETTLE_CYCLES
// clocks, then counts rising edges of the synchronized mux output for
// WINDOW_CYCLES clocks, then presents the count tagged with the channel index
// for one cycle.
// Optional feature: define SCAN_MASK_EN to add the chanMask input. The mask is
// latched when start is accepted, and disabled channels are skipped entirely.
module mux_scan_ctrl #(
   parameter int SELBITS_MUX   = 3,
   parameter int NINPUTS_MUX   = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int WINDOW_CYCLES = 256,
   parameter int CNT_W         = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   muxOut,
`ifdef SCAN_MASK_EN
   input  logic [NINPUTS_MUX-1:0] chanMask,
`endif
   output logic [SELBITS_MUX-1:0] Select,
   output logic [CNT_W-1:0]       count,
   output logic [SELBITS_MUX-1:0] countIndex,
   output logic                   countValid,
   output logic                   busy,
   output logic                   done
);

   localparam int TMAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
   localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, COUNT, REPORT} state_t;

   state_t                 stateQ, stateD;
   logic [TW-1:0]          timerQ, timerD;
   logic [SELBITS_MUX-1:0] selQ, selD;
   logic [CNT_W-1:0]       countQ, countD;
   logic [SELBITS_MUX-1:0] idxQ, idxD;
   logic                   s1Q, s2Q, s3Q;
   logic                   rise;

   logic [NINPUTS_MUX-1:0] startMask;
   logic [NINPUTS_MUX-1:0] enMask;
   logic [SELBITS_MUX-1:0] firstSel, nextSel;
   logic                   anyFirst, hasNext;

`ifdef SCAN_MASK_EN
   logic [NINPUTS_MUX-1:0] maskQ, maskD;
   assign startMask = chanMask;
   assign enMask    = maskQ;
`else
   assign startMask = '1;
   assign enMask    = '1;
`endif

   assign rise = s2Q & ~s3Q;

   // Two-flop synchronizer plus a history flop for edge detection; runs in every state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Q <= 1'b0;
         s2Q <= 1'b0;
         s3Q <= 1'b0;
      end else begin
         s1Q <= muxOut;
         s2Q <= s1Q;
         s3Q <= s2Q;
      end
   end

   // Find the first enabled channel of a new scan and the next enabled channel above Select
   always_comb begin
      firstSel = '0;
      anyFirst = 1'b0;
      nextSel  = selQ;
      hasNext  = 1'b0;
      for (int i = NINPUTS_MUX - 1; i >= 0; i--) begin
         if (startMask[i]) begin
            firstSel = SELBITS_MUX'(i);
            anyFirst = 1'b1;
         end
         if (enMask[i] && (i > int'(selQ))) begin
            nextSel = SELBITS_MUX'(i);
            hasNext = 1'b1;
         end
      end
   end

   // Next-state logic: phase timing, channel stepping and saturating edge count
   always_comb begin
      stateD = stateQ;
      timerD = timerQ;
      selD   = selQ;
      countD = countQ;
      idxD   = idxQ;
`ifdef SCAN_MASK_EN
      maskD  = maskQ;
`endif
      case (stateQ)
         IDLE: begin
            if (start) begin
`ifdef SCAN_MASK_EN
               maskD  = startMask;
`endif
               selD   = firstSel;
               countD = '0;
               timerD = '0;
               stateD = anyFirst ? SETTLE : REPORT;
            end
         end
         SETTLE: begin
            if (timerQ == SETTLE_LAST) begin
               timerD = '0;
               stateD = COUNT;
            end else begin
               timerD = timerQ + TW'(1);
            end
         end
         COUNT: begin
            if (rise && (countQ != '1)) begin
               countD = countQ + CNT_W'(1);
            end
            if (timerQ == WINDOW_LAST) begin
               timerD = '0;
               idxD   = selQ;
               stateD = REPORT;
            end else begin
               timerD = timerQ + TW'(1);
            end
         end
         REPORT: begin
            if (hasNext) begin
               selD   = nextSel;
               countD = '0;
               timerD = '0;
               stateD = SETTLE;
            end else begin
               stateD = IDLE;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any scan in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ <= IDLE;
         timerQ <= '0;
         selQ   <= '0;
         countQ <= '0;
         idxQ   <= '0;
`ifdef SCAN_MASK_EN
         maskQ  <= '0;
`endif
      end else begin
         stateQ <= stateD;
         timerQ <= timerD;
         selQ   <= selD;
         countQ <= countD;
         idxQ   <= idxD;
`ifdef SCAN_MASK_EN
         maskQ  <= maskD;
`endif
      end
   end

   assign Select     = selQ;
   assign count      = countQ;
   assign countIndex = idxQ;
   assign busy       = (stateQ != IDLE);
   assign countValid = (stateQ == REPORT) && (|enMask);
   assign done       = (stateQ == REPORT) && !hasNext;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl
// Randomized scoreboard bench. Each scan's muxOut waveform is planned up front,
// expected per-channel counts are derived from the plan and queued, and a
// monitor pops and compares on every countValid strobe. A second instance with
// a 3-bit counter checks saturation on the same stimulus.
module tb_mux_scan_ctrl;

   localparam int SB  = 3;
   localparam int NCH = 8;
   localparam int SET = 2;
   localparam int WIN = 16;
   localparam int PER = SET + WIN + 1;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic muxOut;
`ifdef SCAN_MASK_EN
   logic [NCH-1:0] chanMask;
`endif

   logic [SB-1:0] Select, countIndex;
   logic [15:0]   count;
   logic          countValid, busy, done;

   logic [SB-1:0] satSelect, satIndex;
   logic [2:0]    satCount;
   logic          satValid, satBusy, satDone;

   typedef struct {
      int idx;
      int cnt;
      bit last;
      int when;
   } exp_t;

   exp_t q[$];
   exp_t qs[$];
   int   checks    = 0;
   int   failures  = 0;
   int   doneSeen  = 0;
   int   satDoneSeen = 0;
   int   cyc       = 0;

   mux_scan_ctrl #(.SELBITS_MUX(SB), .NINPUTS_MUX(NCH), .SETTLE_CYCLES(SET),
                   .WINDOW_CYCLES(WIN), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .muxOut(muxOut),
`ifdef SCAN_MASK_EN
      .chanMask(chanMask),
`endif
      .Select(Select), .count(count), .countIndex(countIndex),
      .countValid(countValid), .busy(busy), .done(done));

   mux_scan_ctrl #(.SELBITS_MUX(SB), .NINPUTS_MUX(NCH), .SETTLE_CYCLES(SET),
                   .WINDOW_CYCLES(WIN), .CNT_W(3)) dutSat (
      .clk(clk), .rst(rst), .start(start), .muxOut(muxOut),
`ifdef SCAN_MASK_EN
      .chanMask(chanMask),
`endif
      .Select(satSelect), .count(satCount), .countIndex(satIndex),
      .countValid(satValid), .busy(satBusy), .done(satDone));

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to time-stamp strobes
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pop the scoreboard on every strobe of either instance
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) doneSeen++;
         if (satDone === 1'b1) satDoneSeen++;
         if (countValid === 1'b1) begin
            if (q.size() == 0) begin
               checkOutput("unexpectedStrobe", countValid, 0);
            end else begin
               e = q.pop_front();
               checkOutput("countIndex", countIndex, e.idx);
               checkOutput("selectInReport", Select, e.idx);
               checkOutput("count", count, e.cnt);
               checkOutput("doneWithLast", done, e.last);
               checkOutput("strobeCycle", cyc, e.when);
            end
         end
         if (satValid === 1'b1) begin
            if (qs.size() == 0) begin
               checkOutput("satUnexpectedStrobe", satValid, 0);
            end else begin
               e = qs.pop_front();
               checkOutput("satIndex", satIndex, e.idx);
               checkOutput("satCount", satCount, (e.cnt > 7) ? 7 : e.cnt);
               checkOutput("satDoneWithLast", satDone, e.last);
               checkOutput("satStrobeCycle", cyc, e.when);
            end
         end
      end
   end

   // One scan: plan waveform, queue expectations, then play it out
   // kind: 0 square period 4, 1 static high, 2 square period 2, 3 sparse random, 4 dense random
   task automatic applyStimulus(input int kind, input logic [NCH-1:0] mask,
                                input int abortAt, input int ignoreAt);
      bit   w[];
      int   nEn, busyExp, len, c0, p, cnt, ph, busyCnt, satBusyCnt, d0, sd0;
      exp_t e;
      nEn     = $countones(mask);
      busyExp = (nEn > 0) ? nEn * PER : 1;
      len     = busyExp + 4;
      w       = new[len];
      ph      = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
         case (kind)
            0: w[i] = (((i + ph) % 4) < 2);
            1: w[i] = 1'b1;
            2: w[i] = ((i + ph) % 2) == 0;
            3: w[i] = (i == 0) ? 1'b0 : (($urandom_range(0, 3) == 0) ? ~w[i-1] : w[i-1]);
            default: w[i] = ($urandom_range(0, 1) == 1);
         endcase
      end
      @(negedge clk);
      c0 = cyc;
      p  = 0;
      for (int ch = 0; ch < NCH; ch++) begin
         if (mask[ch]) begin
            cnt = 0;
            for (int m = p * PER + SET - 1; m <= p * PER + SET + WIN - 2; m++) begin
               if (!w[m-1] && w[m]) cnt++;
            end
            e.idx  = ch;
            e.cnt  = cnt;
            e.last = (p == nEn - 1);
            e.when = c0 + (p + 1) * PER;
            if (abortAt < 0 || (p + 1) * PER < abortAt) begin
               q.push_back(e);
               qs.push_back(e);
            end
            p++;
         end
      end
      busyCnt    = 0;
      satBusyCnt = 0;
      d0         = doneSeen;
      sd0        = satDoneSeen;
      for (int i = 0; i < len; i++) begin
         if (i > 0) @(negedge clk);
         if (i >= 1) begin
            busyCnt    += int'(busy);
            satBusyCnt += int'(satBusy);
         end
         if (i == abortAt) begin
            rst   = 1'b1;
            start = 1'b0;
            @(negedge clk);
            checkOutput("abortSelect", Select, 0);
            checkOutput("abortBusy", busy, 0);
            checkOutput("abortDone", done, 0);
            checkOutput("abortValid", countValid, 0);
            checkOutput("abortSatBusy", satBusy, 0);
            rst = 1'b0;
            break;
         end
         muxOut = w[i];
`ifdef SCAN_MASK_EN
         if (i == 0) chanMask = mask;
`endif
         start = (i == 0) || (i == ignoreAt) || (i == busyExp);
      end
      start = 1'b0;
      if (abortAt < 0) begin
         checkOutput("busyCycles", busyCnt, busyExp);
         checkOutput("satBusyCycles", satBusyCnt, busyExp);
         checkOutput("doneCount", doneSeen - d0, 1);
         checkOutput("satDoneCount", satDoneSeen - sd0, 1);
         checkOutput("idleAfterScan", busy, 0);
      end else begin
         checkOutput("abortNoDone", doneSeen - d0, 0);
      end
      checkOutput("queueDrained", q.size(), 0);
      checkOutput("satQueueDrained", qs.size(), 0);
      q.delete();
      qs.delete();
   endtask

   // Hard bound on simulated time
   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence
   initial begin : mainSeq
      rst    = 1'b1;
      start  = 1'b0;
      muxOut = 1'b0;
`ifdef SCAN_MASK_EN
      chanMask = '1;
`endif
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         muxOut = ~muxOut;
      end
      checkOutput("resetSelect", Select, 0);
      checkOutput("resetCount", count, 0);
      checkOutput("resetIndex", countIndex, 0);
      checkOutput("resetValid", countValid, 0);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetDone", done, 0);
      checkOutput("resetSatCount", satCount, 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         muxOut = ~muxOut;
         checkOutput("idleBusy", busy, 0);
         checkOutput("idleValid", countValid, 0);
      end

      $display("[TB] full scan, square period 4, start pulse during scan");
      applyStimulus(0, 8'hFF, -1, 30);
      $display("[TB] static high input");
      applyStimulus(1, 8'hFF, -1, -1);
      $display("[TB] square period 2 (saturates 3-bit instance)");
      applyStimulus(2, 8'hFF, -1, -1);
      $display("[TB] start ignored in channel 2, reset during channel 3 count");
      applyStimulus(0, 8'hFF, 65, 48);
      $display("[TB] fresh scan after abort");
      applyStimulus(0, 8'hFF, -1, -1);
      for (int r = 0; r < 3; r++) begin
         $display("[TB] random scan %0d", r);
         applyStimulus(3 + (r % 2), 8'hFF, -1, $urandom_range(1, 150));
      end
`ifdef SCAN_MASK_EN
      $display("[TB] masked scan 8'b1010_0101");
      applyStimulus(0, 8'hA5, -1, -1);
      $display("[TB] empty mask");
      applyStimulus(0, 8'h00, -1, -1);
      for (int r = 0; r < 3; r++) begin
         applyStimulus(4, 8'($urandom_range(1, 255)), -1, -1);
      end
`endif
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
